// File: rtl/fpga20_pkg.sv
// Shared constants for the Z180 bus interface: divider defaults and I/O addresses.
// Pure declarations, no logic; no latency or backpressure.
package fpga20_pkg;

    typedef logic [15:0] io_addr_t;

    localparam int PHI_DIV_DEF = 23;
    localparam int CLK_DIV_DEF = 24;

    localparam io_addr_t ADDR_STATUS   = 16'h0100;
    localparam io_addr_t ADDR_SPI_DATA = 16'h0104;
    localparam io_addr_t ADDR_SPI_DUAL = 16'h0105;

endpackage

// File: rtl/bus_sync_frontend_sync2.sv
// Two-flop synchroniser with async active-high reset to 0.
// Latency 2 clk_i cycles; no backpressure.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_sync_frontend.sv
// CLK1-domain front end: synchronised CPU strobes and PHI, PHI rising-edge strobe, LED blinkers.
// Strobes 2 cycles, phi_edge 3 cycles after a sampled PHI rise; no backpressure.
module bus_sync_frontend
    import fpga20_pkg::*;
#(
    parameter int PHI_DIV = PHI_DIV_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic CLK1,
    input  logic RST,
    input  logic PHI,
    input  logic IORQ,
    input  logic RD,
    input  logic WR,
    output logic io_read,
    output logic io_write,
    output logic phi_read,
    output logic phi_edge,
    output logic blink1,
    output logic blink2
);

    logic rd_req;
    logic wr_req;

    assign rd_req = ~IORQ & ~RD;
    assign wr_req = ~IORQ & ~WR;

    sync2 u_sync_rd  (.clk_i(CLK1), .rst_i(RST), .d_i(rd_req), .q_o(io_read));
    sync2 u_sync_wr  (.clk_i(CLK1), .rst_i(RST), .d_i(wr_req), .q_o(io_write));
    sync2 u_sync_phi (.clk_i(CLK1), .rst_i(RST), .d_i(PHI),    .q_o(phi_read));

    logic               prev_q,     prev_d;
    logic               edge_q,     edge_d;
    logic [1:0]         warm_q,     warm_d;
    logic [PHI_DIV-1:0] cnt1_q,     cnt1_d;
    logic               blink1_q,   blink1_d;
    logic [CLK_DIV-1:0] cnt2_q,     cnt2_d;
    logic               blink2_q,   blink2_d;

    // prev is frozen while the PHI synchroniser refills after reset, so a PHI
    // already high at release is not mistaken for a rise.
    always_comb begin
        warm_d   = {warm_q[0], 1'b1};
        prev_d   = warm_q[1] ? phi_read : prev_q;
        edge_d   = phi_read & ~prev_q;
        cnt1_d   = cnt1_q + PHI_DIV'(edge_q);
        blink1_d = blink1_q ^ (edge_q & (&cnt1_q));
        cnt2_d   = cnt2_q + CLK_DIV'(1);
        blink2_d = blink2_q ^ (&cnt2_q);
    end

    always_ff @(posedge CLK1 or posedge RST) begin
        if (RST) begin
            warm_q   <= 2'b00;
            prev_q   <= 1'b1;
            edge_q   <= 1'b0;
            cnt1_q   <= '0;
            blink1_q <= 1'b0;
            cnt2_q   <= '0;
            blink2_q <= 1'b1;
        end else begin
            warm_q   <= warm_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
            cnt1_q   <= cnt1_d;
            blink1_q <= blink1_d;
            cnt2_q   <= cnt2_d;
            blink2_q <= blink2_d;
        end
    end

    assign phi_edge = edge_q;
    assign blink1   = blink1_q;
    assign blink2   = blink2_q;

endmodule

// File: tb/tb_bus_sync_frontend.sv
// Scoreboard bench for bus_sync_frontend with PHI_DIV=2, CLK_DIV=3.
// Stimulus pushes hand-computed expectations keyed by clock half-cycle; a monitor pops and compares.
module tb_bus_sync_frontend;

    logic clk = 1'b0;
    logic rst;
    logic phi;
    logic iorq;
    logic rd;
    logic wr;
    logic io_read;
    logic io_write;
    logic phi_read;
    logic phi_edge;
    logic blink1;
    logic blink2;

    bus_sync_frontend #(.PHI_DIV(2), .CLK_DIV(3)) dut (
        .CLK1     (clk),
        .RST      (rst),
        .PHI      (phi),
        .IORQ     (iorq),
        .RD       (rd),
        .WR       (wr),
        .io_read  (io_read),
        .io_write (io_write),
        .phi_read (phi_read),
        .phi_edge (phi_edge),
        .blink1   (blink1),
        .blink2   (blink2)
    );

    // Observed vector: {io_read, io_write, phi_read, phi_edge, blink1, blink2}
    localparam logic [5:0] M_ALL   = 6'b111111;
    localparam logic [5:0] M_IO    = 6'b110000;
    localparam logic [5:0] M_PHI   = 6'b001100;
    localparam logic [5:0] M_B1    = 6'b000010;
    localparam logic [5:0] M_EDGE  = 6'b000100;
    localparam logic [5:0] RST_VEC = 6'b000001;

    typedef struct {
        int         hc;
        logic [5:0] mask;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   hc     = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(clk);
        hc++;
    end

    initial begin : monitor
        exp_t       e;
        logic [5:0] obs;
        forever begin
            @(clk);
            #2;
            while (sb.size() > 0 && sb[0].hc <= hc) begin
                e   = sb.pop_front();
                obs = {io_read, io_write, phi_read, phi_edge, blink1, blink2};
                n_chk++;
                if (((obs ^ e.val) & e.mask) !== 6'b0) begin
                    n_fail++;
                    $display("FAIL %s at hc=%0d: got %b want %b (mask %b)",
                             e.name, hc, obs, e.val, e.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // p = 0: now (same half-cycle); p >= 1: after the p-th rising edge from now.
    task automatic expect_at(input int p, input logic [5:0] mask, input logic [5:0] val,
                             input string name);
        exp_t e;
        int   i;
        e.hc   = (p == 0) ? hc : hc + 2 * p - 1;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].hc > e.hc) i--;
        sb.insert(i, e);
    endtask

    task automatic reset_pulse();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    task automatic strobe_case(input bit is_wr);
        logic [5:0] on;
        on = is_wr ? 6'b010000 : 6'b100000;
        step();
        iorq = 1'b0;
        if (is_wr) wr = 1'b0;
        else       rd = 1'b0;
        expect_at(1, M_IO, 6'b0, "strobe_lat1");
        expect_at(2, M_IO, on,   "strobe_set");
        expect_at(3, M_IO, on,   "strobe_hold");
        repeat (3) step();
        step();
        rd = 1'b1;
        wr = 1'b1;
        expect_at(1, M_IO, on,   "strobe_rel_lat1");
        expect_at(2, M_IO, 6'b0, "strobe_clr");
        repeat (3) step();
        iorq = 1'b1;
        step();
    endtask

    function automatic logic nsp_phi(input int s);
        return (s < 5) || (s >= 8);
    endfunction

    initial begin : stim
        logic ph_r;
        logic ph_e;
        logic b1;

        rst  = 1'b1;
        phi  = 1'b0;
        iorq = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;

        step();
        expect_at(0, M_ALL, RST_VEC, "reset_init");
        repeat (2) step();

        // Idle run from reset release: blink2 toggles every 8 cycles starting at cycle 8.
        step();
        rst = 1'b0;
        for (int p = 1; p <= 24; p++)
            expect_at(p, M_ALL, ((p / 8) % 2 == 0) ? RST_VEC : 6'b0, "idle_blink2");
        repeat (24) step();

        reset_pulse();
        strobe_case(1'b0);
        strobe_case(1'b1);

        // PHI period 6 cycles with strobes toggling; blink1 toggles after every 4th edge.
        reset_pulse();
        for (int s = 0; s <= 50; s++) begin
            step();
            phi  = (s % 6) < 3;
            iorq = 1'b0;
            rd   = (s % 2) == 1;
            wr   = (s % 2) == 0;
            ph_r = (s >= 1) && (((s - 1) % 6) < 3);
            ph_e = (s >= 2) && (((s - 2) % 6) == 0);
            b1   = (s >= 21) && (s < 45);
            expect_at(1, M_PHI | M_B1, {2'b00, ph_r, ph_e, b1, 1'b0}, "phi_run");
        end

        // Reset lands while phi_edge is high and strobes are active.
        step();
        rst = 1'b1;
        for (int p = 0; p <= 3; p++)
            expect_at(p, M_ALL, RST_VEC, "reset_mid");
        repeat (3) step();
        phi  = 1'b1;
        iorq = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
        repeat (2) step();

        // PHI held high through release: only the later genuine rise is reported.
        for (int s = 0; s <= 13; s++) begin
            step();
            if (s == 0) rst = 1'b0;
            phi  = nsp_phi(s);
            ph_r = (s >= 1) ? nsp_phi(s - 1) : 1'b0;
            ph_e = (s == 10);
            expect_at(1, M_PHI, {2'b00, ph_r, ph_e, 2'b00}, "no_spurious");
        end

        // One-cycle PHI glitch: at most one phi_edge cycle, in the only slot it may occupy.
        phi = 1'b0;
        reset_pulse();
        for (int s = 0; s <= 9; s++) begin
            step();
            phi = (s == 0);
            if (s != 2)
                expect_at(1, M_EDGE, 6'b0, "short_pulse");
        end

        repeat (4) step();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
